// File: rtl/fpu_pkg.sv
// fpu_pkg: FP32 width and divider-arbiter state encoding shared by the divider wrapper blocks
package fpu_pkg;
  localparam int FP_W = 32;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND_A = 3'd1;
  localparam logic [2:0] ST_SEND_B = 3'd2;
  localparam logic [2:0] ST_WAIT_Z = 3'd3;
  localparam logic [2:0] ST_RETURN = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping mod N
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);
  // scan farthest-first so the request nearest to ptr is the last one written
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IDW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/fpu_div_arbiter.sv
// fpu_div_arbiter: round-robin sharing of one stb/ack FP32 divider among N requesters,
// one division in flight; operands are captured at grant and the result is held until taken.
module fpu_div_arbiter
  import fpu_pkg::*;
#(
  parameter int N = 2,
  localparam int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*FP_W-1:0] req_a,
  input  logic [N*FP_W-1:0] req_b,
  input  logic [N-1:0]      req_stb,
  output logic [N-1:0]      req_ack,
  output logic [N*FP_W-1:0] rsp_z,
  output logic [N-1:0]      rsp_stb,
  input  logic [N-1:0]      rsp_ack,
  output logic [FP_W-1:0]   div_a,
  output logic              div_a_stb,
  input  logic              div_a_ack,
  output logic [FP_W-1:0]   div_b,
  output logic              div_b_stb,
  input  logic              div_b_ack,
  input  logic [FP_W-1:0]   div_z,
  input  logic              div_z_stb,
  output logic              div_z_ack,
  output logic              busy,
  output logic [IDW-1:0]    grant_idx
);
  logic [2:0]      state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick_idx;
  logic [N-1:0]    pick_gnt;
  logic [FP_W-1:0] op_a;
  logic [FP_W-1:0] op_b;
  rr_arbiter #(.N(N)) u_rr (
    .req(req_stb),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  assign div_a = op_a;
  assign div_b = op_b;
  // operand and result registers carry no reset: they are only read while their stb is high
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      req_ack   <= '0;
      rsp_stb   <= '0;
      div_a_stb <= 1'b0;
      div_b_stb <= 1'b0;
      div_z_ack <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: if (|req_stb) begin
          op_a      <= req_a[FP_W*pick_idx +: FP_W];
          op_b      <= req_b[FP_W*pick_idx +: FP_W];
          grant_idx <= pick_idx;
          busy      <= 1'b1;
          req_ack   <= pick_gnt;
          div_a_stb <= 1'b1;
          state     <= ST_SEND_A;
        end
        ST_SEND_A: if (div_a_ack) begin
          div_a_stb <= 1'b0;
          div_b_stb <= 1'b1;
          state     <= ST_SEND_B;
        end
        ST_SEND_B: if (div_b_ack) begin
          div_b_stb <= 1'b0;
          div_z_ack <= 1'b1;
          state     <= ST_WAIT_Z;
        end
        ST_WAIT_Z: if (div_z_stb) begin
          rsp_z[FP_W*grant_idx +: FP_W] <= div_z;
          div_z_ack          <= 1'b0;
          rsp_stb[grant_idx] <= 1'b1;
          state              <= ST_RETURN;
        end
        ST_RETURN: if (rsp_ack[grant_idx]) begin
          rsp_stb <= '0;
          busy    <= 1'b0;
          rr_ptr  <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
